// File: rtl/arm_defs_pkg.sv
// Shared constants and encodings for the memory-stage SRAM controller.
package arm_defs;

  localparam int unsigned WORD          = 32;
  localparam int unsigned SRAM_DW       = 16;
  localparam int unsigned SRAM_AW_DEF   = 18;
  localparam int unsigned ADDR_BASE_DEF = 1024;
  localparam int unsigned CNT_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } sram_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } sram_op_e;

endpackage

// File: rtl/sram_phase_counter.sv
// Wait-cycle counter for one half-word bus phase; o_last flags the final cycle.
module sram_phase_counter
  import arm_defs::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_last
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_last = (r_cnt == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// Memory-stage controller: 32-bit loads/stores as two timed half-word phases
// on a 16-bit asynchronous SRAM, stalling the pipeline via ready.
module sram_controller
  import arm_defs::*;
#(
  parameter int unsigned ADDR_BASE   = ADDR_BASE_DEF,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = SRAM_AW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [WORD-1:0]    address,
  input  logic [WORD-1:0]    write_data,
  output logic [WORD-1:0]    read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  inout  wire  [SRAM_DW-1:0] sram_dq,
  output logic               sram_we_n,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  sram_state_e r_state;
  sram_state_e w_state_nxt;
  sram_op_e    r_op;

  logic [SRAM_AW-2:0] r_word;
  logic [SRAM_AW-2:0] w_word_in;
  logic [WORD-1:0]    r_wdata;
  logic [WORD-1:0]    r_rdata;
  logic [SRAM_DW-1:0] r_lo;

  logic               w_req;
  logic               w_accept;
  logic               w_cnt_clr;
  logic               w_cnt_inc;
  logic               w_last;
  logic               w_cap_lo;
  logic               w_cap_hi;
  logic               w_ready;
  logic               w_we_n;
  logic               w_dq_oe;
  logic [SRAM_DW-1:0] w_dq_out;
  logic [SRAM_AW-1:0] w_addr;

  assign w_req = wr_en | rd_en;

  // Word index of the offset from ADDR_BASE; wraps modulo 2^32, byte lane ignored.
  assign w_word_in = (SRAM_AW-1)'((address - ADDR_BASE) >> 2);

  sram_phase_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_phase_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_cnt_clr),
    .i_inc  (w_cnt_inc),
    .o_last (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_READ;
      r_word  <= '0;
      r_wdata <= '0;
      r_lo    <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op    <= wr_en ? OP_WRITE : OP_READ;
        r_word  <= w_word_in;
        r_wdata <= write_data;
      end
      if (w_cap_lo) begin
        r_lo <= sram_dq;
      end
      // High half arrives on the last HI cycle, so the full word is visible from DONE on.
      if (w_cap_hi) begin
        r_rdata <= {sram_dq, r_lo};
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_cap_lo    = 1'b0;
    w_cap_hi    = 1'b0;
    w_ready     = 1'b0;
    w_addr      = '0;
    w_we_n      = 1'b1;
    w_dq_oe     = 1'b0;
    w_dq_out    = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_accept    = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = ST_LO;
        end else begin
          w_ready = 1'b1;
        end
      end

      ST_LO: begin
        w_addr = {r_word, 1'b0};
        if (r_op == OP_WRITE) begin
          w_dq_oe  = 1'b1;
          w_dq_out = r_wdata[SRAM_DW-1:0];
          w_we_n   = 1'b0;
        end
        if (w_last) begin
          w_cnt_clr   = 1'b1;
          w_cap_lo    = (r_op == OP_READ);
          w_state_nxt = ST_HI;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end

      ST_HI: begin
        w_addr = {r_word, 1'b1};
        if (r_op == OP_WRITE) begin
          w_dq_oe  = 1'b1;
          w_dq_out = r_wdata[WORD-1:SRAM_DW];
          w_we_n   = 1'b0;
        end
        if (w_last) begin
          w_cnt_clr   = 1'b1;
          w_cap_hi    = (r_op == OP_READ);
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end

      // Requests present here belong to the pipeline slot that is just advancing.
      ST_DONE: begin
        w_ready     = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign read_data = r_rdata;
  assign ready     = w_ready;
  assign sram_addr = w_addr;
  assign sram_we_n = w_we_n;
  assign sram_dq   = w_dq_oe ? w_dq_out : {SRAM_DW{1'bz}};
  assign sram_ce_n = 1'b0;
  assign sram_oe_n = 1'b0;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed and random loads/stores against a word-level
// memory model, with cycle-accurate bus and stall expectations.
module tb_sram_controller;

  localparam int unsigned W    = 2;
  localparam int unsigned BASE = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  wire  [31:0] read_data;
  wire         ready;
  wire  [17:0] sram_addr;
  wire  [15:0] sram_dq;
  wire         sram_we_n;
  wire         sram_ce_n;
  wire         sram_oe_n;
  wire         sram_ub_n;
  wire         sram_lb_n;

  int unsigned n_tests;
  int unsigned n_fail;
  logic [31:0] exp_rdata;

  // Word-level reference memory; unwritten words read as zero.
  logic [31:0] ref_words [int unsigned];

  // Asynchronous SRAM: outputs whenever not being written, latches data while we_n is low.
  bit [15:0] mem [0:262143];
  assign sram_dq = sram_we_n ? mem[sram_addr] : 16'hzzzz;
  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr] <= sram_dq;
  end

  always #5 clk = ~clk;

  sram_controller #(
    .ADDR_BASE   (BASE),
    .WAIT_CYCLES (W),
    .SRAM_AW     (18)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq    (sram_dq),
    .sram_we_n  (sram_we_n),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n)
  );

  function automatic int unsigned widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off >> 2) & 32'h1FFFF;
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned w);
    return ref_words.exists(w) ? ref_words[w] : 32'h0;
  endfunction

  function automatic logic [15:0] ref_half(input int unsigned h);
    logic [31:0] v;
    v = ref_word(h / 2);
    return (h % 2 == 1) ? v[31:16] : v[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full request/response; returns after sampling the DONE cycle.
  task automatic txn(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
    bit          is_wr;
    int unsigned w;
    int unsigned h;
    logic [15:0] half;
    logic [31:0] rd_val;
    is_wr  = wr;
    w      = widx(a);
    rd_val = ref_word(w);
    @(posedge clk); #1;
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    @(negedge clk);
    check("req_ready", 32'(ready), 32'd0);
    check("req_addr",  32'(sram_addr), 32'd0);
    check("req_we_n",  32'(sram_we_n), 32'd1);
    check("req_rdata", read_data, exp_rdata);
    for (int c = 1; c <= 2 * W; c++) begin
      @(negedge clk);
      h    = 2 * w + ((c > W) ? 1 : 0);
      half = (c > W) ? d[31:16] : d[15:0];
      check("busy_ready", 32'(ready), 32'd0);
      check("phase_addr", 32'(sram_addr), 32'(h));
      check("phase_we_n", 32'(sram_we_n), 32'(!is_wr));
      check("phase_dq",   32'(sram_dq), 32'(is_wr ? half : ref_half(h)));
      check("busy_rdata", read_data, exp_rdata);
    end
    if (is_wr) ref_words[w] = d;
    @(negedge clk);
    check("done_ready", 32'(ready), 32'd1);
    check("done_addr",  32'(sram_addr), 32'd0);
    check("done_we_n",  32'(sram_we_n), 32'd1);
    check("done_dq",    32'(sram_dq), 32'(ref_half(0)));
    if (!is_wr) exp_rdata = rd_val;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(ready), 32'd1);
    check("idle_addr",  32'(sram_addr), 32'd0);
    check("idle_we_n",  32'(sram_we_n), 32'd1);
    check("idle_rdata", read_data, exp_rdata);
  endtask

  initial begin
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] a;
    int unsigned op;
    int unsigned w;

    n_tests = 0; n_fail = 0; exp_rdata = 32'h0;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_rdata", read_data, 32'd0);
    check("rst_we_n",  32'(sram_we_n), 32'd1);
    check("rst_addr",  32'(sram_addr), 32'd0);
    check("rst_ties",  32'({sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n}), 32'd0);

    // Basic store then load of the first word.
    txn(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    txn(1'b0, 1'b1, 32'd1024, 32'h0);
    idle();

    // Byte offset within a word must not change the mapping.
    d1 = $urandom; d2 = $urandom;
    txn(1'b1, 1'b0, 32'd1028, d1);
    txn(1'b1, 1'b0, 32'd1030, d2);
    txn(1'b0, 1'b1, 32'd1029, 32'h0);
    idle();

    // Both requests asserted: store wins, read_data untouched.
    txn(1'b1, 1'b1, 32'd1024, 32'h12345678);
    idle();

    // Load held through DONE, then a store issued with no gap.
    txn(1'b0, 1'b1, 32'd1024, 32'h0);
    txn(1'b1, 1'b0, 32'd1036, 32'hA5A55A5A);
    txn(1'b0, 1'b1, 32'd1036, 32'h0);
    idle();

    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 2);
      if (i % 5 == 4) a = $urandom;
      else            a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      case (op)
        0:       txn(1'b0, 1'b1, a, $urandom);
        1:       txn(1'b1, 1'b0, a, $urandom);
        default: txn(1'b1, 1'b1, a, $urandom);
      endcase
      if ($urandom_range(0, 1) == 1) idle();
    end

    // Make read_data non-zero, then reset in the HI phase of a store.
    txn(1'b0, 1'b1, 32'd1036, 32'h0);
    idle();
    a  = BASE + 32'h40;
    d1 = $urandom;
    w  = widx(a);
    @(posedge clk); #1;
    wr_en = 1'b1; rd_en = 1'b0; address = a; write_data = d1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_rst_addr", 32'(sram_addr), 32'(2 * w + 1));
    check("pre_rst_we_n", 32'(sram_we_n), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; wr_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    // Both halves were on the bus with we_n low before the reset edge.
    ref_words[w] = d1;
    exp_rdata    = 32'h0;
    @(negedge clk);
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_we_n",  32'(sram_we_n), 32'd1);
    check("mid_rst_addr",  32'(sram_addr), 32'd0);
    check("mid_rst_dq",    32'(sram_dq), 32'(ref_half(0)));
    check("mid_rst_rdata", read_data, 32'd0);
    txn(1'b0, 1'b1, a, 32'h0);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
